// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS Lite sequencing controller (optional PERF_CNT_EN performance counters)
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Next-state and sticky illegal-decode flag
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    if (!reset) begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  state_d = memready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        // Only LW or SW reach MEMADR, so anything but SW is a load
        S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_d = memready ? S_MEMWB : S_MEMRD;
        S_MEMWR:  state_d = memready ? S_FETCH : S_MEMWR;
        S_EXECUTE: begin
          state_d = S_ALUWB;
          case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ;
            default: illegal_d = 1'b1;
          endcase
        end
        S_ADDIEX: state_d = S_ADDIWB;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // State and illegal flag registers
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    illegal_q <= illegal_d;
  end

  // Moore datapath controls; pcen/irwrite/memwrite also follow zero/memready
  always_comb begin
    memreq     = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    case (state_q)
      S_FETCH: begin
        memreq     = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite    = memready;
        pcen       = memready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        iord     = 1'b1;
        memwrite = memready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = zero;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    // Hold every strobe and select low while reset is asserted
    if (!reset) begin
      memreq     = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             instr_done;

  // Retire detection and counter next values
  always_comb begin
    instr_done = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: instr_done = 1'b1;
      S_MEMWR: instr_done = memready;
      default: instr_done = 1'b0;
    endcase
    if (!reset) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      instr_cnt_d = instr_done ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    cycle_cnt_q <= cycle_cnt_d;
    instr_cnt_q <= instr_cnt_d;
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memreq, iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .memreq(memreq), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state),
    .illegal(illegal)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] vec;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // Expected controls for one cycle: {state, memreq, iord, memwrite, irwrite, pcen,
  // regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal}
  function automatic logic [20:0] ref_out(input int st, input logic mr, input logic rs,
                                          input logic z, input logic [5:0] fn, input logic ill);
    logic mq, io, mw, ir, pe, rd, mt, rw, sa;
    logic [1:0] sb2, ps;
    logic [2:0] ac;
    {mq, io, mw, ir, pe, rd, mt, rw, sa} = '0;
    sb2 = 2'b00; ps = 2'b00; ac = 3'b000;
    if (rs) begin
      case (st)
        0:  begin mq = 1; sb2 = 2'b01; ac = 3'b010; ir = mr; pe = mr; end
        1:  begin sb2 = 2'b11; ac = 3'b010; end
        2:  begin sa = 1; sb2 = 2'b10; ac = 3'b010; end
        3:  begin mq = 1; io = 1; end
        4:  begin rw = 1; mt = 1; end
        5:  begin mq = 1; io = 1; mw = mr; end
        6:  begin
              sa = 1;
              if (fn == 6'b100010) ac = 3'b110;
              else if (fn == 6'b100100) ac = 3'b000;
              else if (fn == 6'b100101) ac = 3'b001;
              else if (fn == 6'b101010) ac = 3'b111;
              else ac = 3'b010;
            end
        7:  begin rw = 1; rd = 1; end
        8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
        9:  begin sa = 1; sb2 = 2'b10; ac = 3'b010; end
        10: rw = 1;
        11: begin ps = 2'b10; pe = 1; end
        default: ;
      endcase
    end
    return {st[3:0], mq, io, mw, ir, pe, rd, mt, rw, sa, sb2, ps, ac, ill};
  endfunction

  // Drive one cycle and push its expected outputs
  task automatic cyc(input int st, input logic mr, input logic ill);
    exp_t e;
    memready = mr;
    e.vec = ref_out(st, mr, reset, zero, funct, ill);
    e.tag = $sformatf("c%0d_st%0d", cyc_n, st);
    sb.push_back(e);
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs against the scoreboard at mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {11'd0, state, memreq, iord, memwrite, irwrite, pcen, regdst, memtoreg,
                    regwrite, alusrca, alusrcb, pcsrc, alucontrol, illegal}, {11'd0, e.vec});
    end
  end

  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
  endtask

  initial begin
    reset = 1'b0; memready = 1'b1; op = '0; funct = '0; zero = 1'b0;
    @(posedge clk); #1;
    cyc(0, 1, 0);                          // second reset cycle: strobes forced low
    reset = 1'b1;

    instr(6'b000010, 6'd0, 0);             // j: 3 cycles
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(11, 1, 0);
    instr(6'b101011, 6'd0, 0);             // sw: 4 cycles
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(5, 1, 0);
    instr(6'b100011, 6'd0, 0);             // lw: 5 cycles
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(3, 1, 0); cyc(4, 1, 0);
`ifdef PERF_CNT_EN
    check("cycle_cnt", cycle_cnt, 32'd12);
    check("instr_cnt", instr_cnt, 32'd3);
`endif

    instr(6'b000000, 6'b100000, 0);        // add
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(6, 1, 0); cyc(7, 1, 0);
    instr(6'b100011, 6'd0, 0);             // lw with three MEMRD waits: 8 cycles
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0);
    cyc(3, 0, 0); cyc(3, 0, 0); cyc(3, 0, 0); cyc(3, 1, 0); cyc(4, 1, 0);
    instr(6'b000000, 6'b100010, 0);        // sub with a FETCH wait
    cyc(0, 0, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(6, 1, 0); cyc(7, 1, 0);
    instr(6'b101011, 6'd0, 0);             // sw with a MEMWR wait
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(2, 1, 0); cyc(5, 0, 0); cyc(5, 1, 0);
    instr(6'b000100, 6'd0, 1);             // beq taken
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(8, 1, 0);
    instr(6'b000100, 6'd0, 0);             // beq not taken
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(8, 1, 0);
    instr(6'b111111, 6'd0, 0);             // illegal op
    cyc(0, 1, 0); cyc(1, 1, 0);
    instr(6'b001000, 6'd0, 0);             // addi, illegal stays set
    cyc(0, 1, 1); cyc(1, 1, 1); cyc(9, 1, 1); cyc(10, 1, 1);
    instr(6'b100011, 6'd0, 0);             // lw interrupted by reset in MEMRD
    cyc(0, 1, 1); cyc(1, 1, 1); cyc(2, 1, 1); cyc(3, 0, 1);
    reset = 1'b0;
    cyc(3, 0, 1);
    reset = 1'b1;
    instr(6'b000000, 6'b100100, 0);        // and
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(6, 1, 0); cyc(7, 1, 0);
    instr(6'b000000, 6'b100101, 0);        // or
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(6, 1, 0); cyc(7, 1, 0);
    instr(6'b000000, 6'b101010, 0);        // slt
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(6, 1, 0); cyc(7, 1, 0);
    instr(6'b000000, 6'b111000, 0);        // bad funct still completes
    cyc(0, 1, 0); cyc(1, 1, 0); cyc(6, 1, 0); cyc(7, 1, 1); cyc(0, 1, 1);

    @(negedge clk); #1;
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
